// File: rtl/rr_encoder_8_3.sv
// Round-robin 8:3 priority encoder with a registered grant held until accepted.
// Latency: 1 cycle from req sampled in IDLE to grant_valid; at least 1 IDLE cycle after each handshake.
// Backpressure: the grant is held stable while out_ready=0; ptr advances only on grant_valid & out_ready.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset (wins over handshake and new requests)
//   req          request vector, bit i = requester i pending
//   out_ready    consumer accepts the presented grant this cycle
//   grant_valid  a grant is presented
//   grant_idx    binary index of the granted requester (kept while idle)
//   grant_onehot one-hot form of grant_idx, zero while idle
//   ptr          round-robin scan start position (debug)
module rr_encoder_8_3 #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         grant_valid,
   output logic [W-1:0] grant_idx,
   output logic [N-1:0] grant_onehot,
   output logic [W-1:0] ptr
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t         state_q;
   logic           grant_valid_q;
   logic [W-1:0]   grant_idx_q;
   logic [N-1:0]   grant_onehot_q;
   logic [W-1:0]   ptr_q;

   logic [W-1:0]   win_idx_d;
   logic [N-1:0]   win_onehot_d;
   logic [W-1:0]   ptr_d;
   logic           handshake;

   // Scan from the highest offset down so the lowest offset from ptr_q is the
   // last assignment and therefore wins. N is a power of two, so the W-bit add
   // wraps modulo N on its own.
   always_comb begin
      logic [W-1:0] cand;
      win_idx_d = '0;
      cand      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = ptr_q + W'(k);
         if (req[cand]) begin
            win_idx_d = cand;
         end
      end
   end

   assign win_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx_d;
   assign ptr_d        = grant_idx_q + 1'b1;
   assign handshake    = grant_valid_q & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         grant_valid_q  <= 1'b0;
         grant_idx_q    <= '0;
         grant_onehot_q <= '0;
         ptr_q          <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // With no requests, stay put and leave ptr alone.
               if (|req) begin
                  grant_idx_q    <= win_idx_d;
                  grant_onehot_q <= win_onehot_d;
                  grant_valid_q  <= 1'b1;
                  state_q        <= HOLD;
               end
            end
            HOLD: begin
               // Grant is frozen regardless of req until the consumer takes it.
               if (handshake) begin
                  ptr_q          <= ptr_d;
                  grant_valid_q  <= 1'b0;
                  grant_onehot_q <= '0;
                  state_q        <= IDLE;
               end
            end
            default: begin
               state_q        <= IDLE;
               grant_valid_q  <= 1'b0;
               grant_onehot_q <= '0;
            end
         endcase
      end
   end

   assign grant_valid  = grant_valid_q;
   assign grant_idx    = grant_idx_q;
   assign grant_onehot = grant_onehot_q;
   assign ptr          = ptr_q;

endmodule

// File: tb/tb_rr_encoder_8_3.sv
// Self-checking bench for rr_encoder_8_3.
// Expected grants are queued when stimulus is applied and popped on each handshake.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_rr_encoder_8_3;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       out_ready;
   logic       grant_valid;
   logic [2:0] grant_idx;
   logic [7:0] grant_onehot;
   logic [2:0] ptr;

   rr_encoder_8_3 #(.N(8), .W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .out_ready    (out_ready),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .grant_onehot (grant_onehot),
      .ptr          (ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] idx;     // grant expected at handshake
      logic [2:0] ptr;     // ptr expected after handshake
      logic       gap;     // check 2-cycle spacing from previous handshake
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_hs = 0;
   logic ptr_pend = 1'b0;
   logic [2:0] ptr_exp = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] oh;
      if (ptr_pend && !rst) begin
         chk("ptr_after_hs", ptr, ptr_exp);
         chk("idle_after_hs", grant_valid, 1'b0);
         chk("onehot_idle", grant_onehot, 8'h00);
      end
      ptr_pend = 1'b0;
      if (!rst && grant_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_grant", grant_idx, 3'h0);
            chk("unexpected_grant_cnt", 1, 0);
         end else begin
            e  = sb.pop_front();
            oh = 8'b1 << e.idx;
            chk("grant_idx", grant_idx, e.idx);
            chk("grant_onehot", grant_onehot, oh);
            if (e.gap) chk("grant_gap", cyc - last_hs, 2);
            ptr_pend = 1'b1;
            ptr_exp  = e.ptr;
         end
         last_hs = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 8'h00;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic push(input logic [2:0] idx, input logic [2:0] p, input logic gap);
      exp_t e;
      e.idx = idx;
      e.ptr = p;
      e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         step();
         n++;
      end
      if (sb.size() != 0) begin
         chk({tag, "_timeout"}, sb.size(), 0);
         sb.delete();
      end
      req = 8'h00;
      out_ready = 1'b0;
      step();
      step();
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!grant_valid && n < 20) begin
         step();
         n++;
      end
      if (!grant_valid) chk({tag, "_valid_timeout"}, grant_valid, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      req = 8'h00;
      out_ready = 1'b0;

      // Reset state; no requests with out_ready high does nothing.
      do_reset();
      @(negedge clk);
      chk("rst_valid", grant_valid, 1'b0);
      chk("rst_idx", grant_idx, 3'd0);
      chk("rst_onehot", grant_onehot, 8'h00);
      chk("rst_ptr", ptr, 3'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("noreq_valid", grant_valid, 1'b0);
         chk("noreq_ptr", ptr, 3'd0);
      end
      out_ready = 1'b0;

      // Two requesters alternate: 5,7,5,7.
      do_reset();
      push(3'd5, 3'd6, 1'b0);
      push(3'd7, 3'd0, 1'b1);
      push(3'd5, 3'd6, 1'b1);
      push(3'd7, 3'd0, 1'b1);
      req = 8'b1010_0000;
      out_ready = 1'b1;
      drain("alt57", 40);

      // All requesting: full rotation with wrap.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         push(3'(i), 3'(i + 1), i != 0);
      end
      req = 8'hFF;
      out_ready = 1'b1;
      drain("rotate", 60);

      // Grant held under backpressure while req changes.
      do_reset();
      req = 8'h08;
      wait_valid("hold");
      req = 8'h01;
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         chk("hold_valid", grant_valid, 1'b1);
         chk("hold_idx", grant_idx, 3'd3);
         chk("hold_onehot", grant_onehot, 8'h08);
         chk("hold_ptr", ptr, 3'd0);
      end
      step();
      push(3'd3, 3'd4, 1'b0);
      push(3'd0, 3'd1, 1'b1);
      out_ready = 1'b1;
      drain("hold", 30);

      // Reset while holding a grant for requester 6.
      do_reset();
      req = 8'h40;
      wait_valid("rst_hold");
      chk("rst_hold_idx", grant_idx, 3'd6);
      rst = 1'b1;
      req = 8'h41;
      step();
      @(negedge clk);
      chk("rst_hold_valid", grant_valid, 1'b0);
      chk("rst_hold_ptr", ptr, 3'd0);
      step();
      push(3'd0, 3'd1, 1'b0);
      rst = 1'b0;
      out_ready = 1'b1;
      drain("rst_hold", 30);

      // Reset on the same edge as a handshake.
      do_reset();
      req = 8'h04;
      wait_valid("rst_hs");
      chk("rst_hs_idx", grant_idx, 3'd2);
      rst = 1'b1;
      out_ready = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b0;
      req = 8'h00;
      @(negedge clk);
      chk("rst_hs_ptr", ptr, 3'd0);
      chk("rst_hs_valid", grant_valid, 1'b0);
      step();
      push(3'd0, 3'd1, 1'b0);
      req = 8'hFF;
      out_ready = 1'b1;
      drain("rst_hs", 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
